// File: rtl/instr_fetch_unit.sv
// PC and instruction-register stage of the multi-cycle MIPS core: fetches words over a
// req/ready handshake, decodes IR fields and applies control-unit PC updates.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_instr_write,
  input  logic                  i_pc_write,
  input  logic                  i_branch,
  input  logic                  i_zero,
  input  logic [1:0]            i_pc_source,
  input  logic [ADDR_WIDTH-1:0] i_alu_result,
  input  logic [ADDR_WIDTH-1:0] i_alu_out,
  output logic                  o_imem_req,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [31:0]           i_imem_rdata,
  input  logic                  i_imem_ready,
  output logic                  o_fetch_stall,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [31:0]           o_instr,
  output logic [5:0]            o_opcode,
  output logic [4:0]            o_rs,
  output logic [4:0]            o_rt,
  output logic [4:0]            o_rd,
  output logic [4:0]            o_shamt,
  output logic [5:0]            o_funct,
  output logic [15:0]           o_imm,
  output logic                  o_instr_valid,
  output logic                  o_misaligned,
  output logic [15:0]           o_fetch_count
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_start;
  logic                    w_ir_load;
  logic                    w_ready_cycle;
  logic                    w_pc_en;
  logic                    w_pc_hold;
  logic                    w_pc_update;
  logic [ADDR_WIDTH-1:0]   w_pc_target;
  logic [ADDR_WIDTH-1:0]   w_jump_target;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [31:0]             r_instr;
  logic                    r_instr_valid;
  logic                    r_misaligned;
  logic [15:0]             r_fetch_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_ir_load    = 1'b0;
    case (r_state)
      S_IDLE: if (i_instr_write) begin
        w_next_state = S_WAIT;
        w_start      = 1'b1;
      end
      S_WAIT: if (i_imem_ready) begin
        w_next_state = S_IDLE;
        w_ir_load    = 1'b1;
      end
    endcase
  end

  assign w_ready_cycle = (r_state == S_WAIT) & i_imem_ready;
  assign o_fetch_stall = i_instr_write & ~w_ready_cycle;
  assign w_pc_en       = (i_pc_write | (i_branch & i_zero)) & ~o_fetch_stall
                       & ((r_state == S_IDLE) | i_imem_ready);

  // Jump target is built from the IR as it stands, even on the edge that reloads it.
  assign w_jump_target = {r_pc[ADDR_WIDTH-1:28], r_instr[25:0], 2'b00};

  always_comb begin
    w_pc_target = r_pc;
    w_pc_hold   = 1'b0;
    case (i_pc_source)
      2'b00: w_pc_target = i_alu_result;
      2'b01: w_pc_target = i_alu_out;
      2'b10: w_pc_target = w_jump_target;
      2'b11: w_pc_hold   = 1'b1;
    endcase
  end

  assign w_pc_update = w_pc_en & ~w_pc_hold;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_pc_update & (|w_pc_target[1:0]);
      if (w_pc_update) r_pc <= {w_pc_target[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      if (w_start) r_instr_valid <= 1'b0;
      if (w_ir_load) begin
        r_instr       <= i_imem_rdata;
        r_instr_valid <= 1'b1;
        r_fetch_count <= r_fetch_count + 16'd1;
      end
    end
  end

  assign o_imem_req    = (r_state == S_WAIT);
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_instr       = r_instr;
  assign o_opcode      = r_instr[31:26];
  assign o_rs          = r_instr[25:21];
  assign o_rt          = r_instr[20:16];
  assign o_rd          = r_instr[15:11];
  assign o_shamt       = r_instr[10:6];
  assign o_funct       = r_instr[5:0];
  assign o_imm         = r_instr[15:0];
  assign o_instr_valid = r_instr_valid;
  assign o_misaligned  = r_misaligned;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed stimulus, fetch completions checked by a
// scoreboard monitor, PC/handshake behaviour checked inline.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_instr_write, i_pc_write, i_branch, i_zero, i_imem_ready;
  logic [1:0]  i_pc_source;
  logic [31:0] i_alu_result, i_alu_out, i_imem_rdata;
  logic        o_imem_req, o_fetch_stall, o_instr_valid, o_misaligned;
  logic [31:0] o_imem_addr, o_pc, o_instr;
  logic [5:0]  o_opcode, o_funct;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [15:0] o_imm, o_fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [15:0] cnt;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  instr_fetch_unit dut (
    .clock(clock), .reset(reset),
    .i_instr_write(i_instr_write), .i_pc_write(i_pc_write), .i_branch(i_branch),
    .i_zero(i_zero), .i_pc_source(i_pc_source), .i_alu_result(i_alu_result),
    .i_alu_out(i_alu_out), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_rdata(i_imem_rdata), .i_imem_ready(i_imem_ready),
    .o_fetch_stall(o_fetch_stall), .o_pc(o_pc), .o_instr(o_instr),
    .o_opcode(o_opcode), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
    .o_funct(o_funct), .o_imm(o_imm), .o_instr_valid(o_instr_valid),
    .o_misaligned(o_misaligned), .o_fetch_count(o_fetch_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [5:0] op,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
                          input logic [15:0] cnt, input logic [31:0] pc);
    exp_t e;
    e.instr = instr; e.op = op; e.rs = rs; e.rt = rt; e.rd = rd;
    e.sh = sh; e.fn = fn; e.imm = imm; e.cnt = cnt; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: a change of fetch_count outside reset marks a completed fetch.
  initial begin : monitor
    logic [15:0] m_last;
    exp_t        e;
    m_last = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        m_last = o_fetch_count;
      end else if (o_fetch_count != m_last) begin
        m_last = o_fetch_count;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_fetch: got instr %h count %0d, expected no fetch",
                   o_instr, o_fetch_count);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", o_instr, e.instr);
          check("sb_opcode", 32'(o_opcode), 32'(e.op));
          check("sb_rs", 32'(o_rs), 32'(e.rs));
          check("sb_rt", 32'(o_rt), 32'(e.rt));
          check("sb_rd", 32'(o_rd), 32'(e.rd));
          check("sb_shamt", 32'(o_shamt), 32'(e.sh));
          check("sb_funct", 32'(o_funct), 32'(e.fn));
          check("sb_imm", 32'(o_imm), 32'(e.imm));
          check("sb_count", 32'(o_fetch_count), 32'(e.cnt));
          check("sb_pc", o_pc, e.pc);
          check("sb_valid", 32'(o_instr_valid), 32'd1);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    i_instr_write = 0; i_pc_write = 0; i_branch = 0; i_zero = 0; i_imem_ready = 0;
    i_pc_source = 2'b00; i_alu_result = '0; i_alu_out = '0; i_imem_rdata = '0;
    #12;
    check("rst_pc", o_pc, 32'h0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_opcode", 32'(o_opcode), 32'h0);
    check("rst_valid", 32'(o_instr_valid), 32'd0);
    check("rst_req", 32'(o_imem_req), 32'd0);
    check("rst_misaligned", 32'(o_misaligned), 32'd0);
    check("rst_count", 32'(o_fetch_count), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Zero-wait fetch: lw $2, 4($1)
    i_instr_write = 1; #1;
    check("f1_stall_idle", 32'(o_fetch_stall), 32'd1);
    check("f1_req_idle", 32'(o_imem_req), 32'd0);
    step();
    check("f1_req_wait", 32'(o_imem_req), 32'd1);
    check("f1_addr", o_imem_addr, 32'h0);
    i_imem_ready = 1; i_imem_rdata = 32'h8C22_0004;
    push_exp(32'h8C22_0004, 6'h23, 5'd1, 5'd2, 5'd0, 5'd0, 6'h04, 16'h0004, 16'd1, 32'h0);
    #1;
    check("f1_stall_ready", 32'(o_fetch_stall), 32'd0);
    step();
    check("f1_no_refetch", 32'(o_imem_req), 32'd0);
    i_instr_write = 0; i_imem_ready = 0;
    step();

    // Three wait states; PC writes blocked until the ready cycle, which loads pc=4.
    i_instr_write = 1; i_pc_write = 1; i_pc_source = 2'b00; i_alu_result = 32'h4; #1;
    check("f2_stall_c0", 32'(o_fetch_stall), 32'd1);
    check("f2_req_c0", 32'(o_imem_req), 32'd0);
    step();
    check("f2_valid_cleared", 32'(o_instr_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("f2_stall_wait", 32'(o_fetch_stall), 32'd1);
      check("f2_req_wait", 32'(o_imem_req), 32'd1);
      check("f2_pc_hold", o_pc, 32'h0);
      step();
    end
    i_imem_ready = 1; i_imem_rdata = 32'h0022_1820;
    push_exp(32'h0022_1820, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1820, 16'd2, 32'h4);
    #1;
    check("f2_req_ready", 32'(o_imem_req), 32'd1);
    check("f2_stall_ready", 32'(o_fetch_stall), 32'd0);
    check("f2_addr_stable", o_imem_addr, 32'h0);
    step();
    i_instr_write = 0; i_imem_ready = 0; i_pc_write = 0;
    check("f2_pc_same_edge", o_pc, 32'h4);

    // Branches
    i_branch = 1; i_zero = 0; i_pc_source = 2'b01; i_alu_out = 32'h40;
    step();
    check("br_not_taken", o_pc, 32'h4);
    i_zero = 1;
    step();
    check("br_taken", o_pc, 32'h40);
    check("br_no_misaligned", 32'(o_misaligned), 32'd0);
    i_branch = 0; i_zero = 0;

    // Jump: in the ready cycle the target comes from the old IR (0x0022_1820).
    i_pc_write = 1; i_pc_source = 2'b00; i_alu_result = 32'h1000_0000;
    step();
    check("set_pc", o_pc, 32'h1000_0000);
    i_pc_write = 0; i_instr_write = 1;
    step();
    i_imem_ready = 1; i_imem_rdata = 32'h0800_0010; i_pc_write = 1; i_pc_source = 2'b10;
    push_exp(32'h0800_0010, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h10, 16'h0010, 16'd3,
             32'h1088_6080);
    step();
    i_imem_ready = 0; i_instr_write = 0;
    check("jump_old_ir", o_pc, 32'h1088_6080);
    step();
    check("jump_new_ir", o_pc, 32'h1000_0040);

    // Misaligned target, then a one-cycle pulse, then source 11 holds silently.
    i_pc_source = 2'b00; i_alu_result = 32'h7;
    step();
    check("mis_pc", o_pc, 32'h4);
    check("mis_pulse", 32'(o_misaligned), 32'd1);
    i_pc_write = 0;
    step();
    check("mis_one_cycle", 32'(o_misaligned), 32'd0);
    i_pc_write = 1; i_pc_source = 2'b11;
    step();
    check("hold_pc", o_pc, 32'h4);
    check("hold_no_mis", 32'(o_misaligned), 32'd0);
    i_pc_write = 0;

    // Reset in the middle of a wait
    i_instr_write = 1;
    step();
    check("rw_req", 32'(o_imem_req), 32'd1);
    check("rw_addr", o_imem_addr, 32'h4);
    #2;
    reset = 1; i_instr_write = 0; #1;
    check("rw_req_async", 32'(o_imem_req), 32'd0);
    check("rw_pc", o_pc, 32'h0);
    check("rw_instr", o_instr, 32'h0);
    check("rw_valid", 32'(o_instr_valid), 32'd0);
    check("rw_count", 32'(o_fetch_count), 32'd0);
    @(posedge clock); #1;
    reset = 0; i_imem_ready = 1; i_imem_rdata = 32'h1022_FFFC;
    step();
    i_imem_ready = 0;
    check("late_ready_valid", 32'(o_instr_valid), 32'd0);
    check("late_ready_count", 32'(o_fetch_count), 32'd0);
    check("late_ready_instr", o_instr, 32'h0);
    check("late_ready_req", 32'(o_imem_req), 32'd0);

    // Fresh fetch after reset: beq $1, $2, -4
    i_instr_write = 1;
    step();
    i_imem_ready = 1;
    push_exp(32'h1022_FFFC, 6'h04, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3C, 16'hFFFC, 16'd1, 32'h0);
    step();
    i_instr_write = 0; i_imem_ready = 0;
    step();
    step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter and instruction-register stage of the multi-cycle MIPS core, directly upstream of the control unit. It holds the PC and fetches instruction words from instruction memory through a request/ready handshake. It latches each word into the instruction register and drives the decoded fields (opcode, rs, rt, rd, shamt, funct, imm) to the control unit and register file. It also applies the control unit's pc_write/branch/pc_source commands and stalls the control FSM while a fetch is outstanding.

## Interface
- ADDR_WIDTH, 32, width of PC and instruction-memory address
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- instr_write  in  1  control request to fetch the word at pc into IR
- pc_write  in  1  unconditional PC update
- branch  in  1  conditional PC update, taken when zero=1
- zero  in  1  ALU zero flag
- pc_source  in  2  00 alu_result, 01 alu_out, 10 jump target, 11 hold
- alu_result  in  ADDR_WIDTH  combinational ALU output (PC+4 path)
- alu_out  in  ADDR_WIDTH  registered ALU output (branch target)
- imem_req  out  1  fetch request, registered
- imem_addr  out  ADDR_WIDTH  fetch address, equals pc
- imem_rdata  in  32  instruction word
- imem_ready  in  1  imem_rdata valid; completes the request
- fetch_stall  out  1  control unit must hold its state
- pc  out  ADDR_WIDTH  current PC
- instr  out  32  instruction register
- opcode/rs/rt/rd/shamt/funct/imm  out  6/5/5/5/5/6/16  IR[31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0]/[15:0]
- instr_valid  out  1  IR holds a completed fetch
- misaligned  out  1  one-cycle pulse: written PC target had nonzero bits [1:0]
- fetch_count  out  16  completed fetches, wraps

## Operation
- Fetch FSM, two states:
  - IDLE: on instr_write=1, go to WAIT, set imem_req=1 and clear instr_valid.
  - WAIT: imem_req is held at 1. On imem_ready=1, load IR from imem_rdata, set instr_valid=1, increment fetch_count, clear imem_req and return to IDLE.
- imem_ready in IDLE is ignored.
- fetch_stall = instr_write & ~(state==WAIT & imem_ready). This is combinational.
- PC update enable: pc_en = (pc_write | (branch & zero)) & ~fetch_stall & (state==IDLE | imem_ready). The PC never changes while imem_req=1 and no ready has arrived.
- Next PC selection:
  - 00 selects alu_result.
  - 01 selects alu_out.
  - 10 selects {pc[31:28], instr[25:0], 2'b00}.
  - 11 keeps pc unchanged, with no misaligned pulse.
- The next PC is written with bits [1:0] forced to 0. misaligned pulses for one cycle when the selected source had nonzero [1:0] and pc_en=1.
- Simultaneous pc_en and IR load in the ready cycle:
  - The jump target uses the old IR.
  - Both registers update on the same edge.
- fetch_count wraps from 16'hFFFF to 0.
- Field outputs decode IR continuously. They are meaningful only when instr_valid=1.

## Timing
- Reset values:
  - pc=RESET_PC, instr=0, so all decoded fields are 0.
  - instr_valid=0, imem_req=0, misaligned=0, fetch_count=0, FSM=IDLE.
- Reset asserted mid-WAIT:
  - imem_req drops immediately (asynchronous).
  - A late imem_ready after reset release, while in IDLE, is ignored.
- Minimum fetch latency, zero-wait memory:
  - Cycle N: instr_write=1 and fetch_stall=1.
  - Edge after N: FSM enters WAIT and imem_req goes to 1.
  - Cycle N+1: imem_ready=1 and fetch_stall=0.
  - Edge after N+1: IR loads and instr_valid=1.
- Each wait cycle of memory adds exactly one stall cycle.
- imem_addr is stable for the whole time imem_req=1.
- instr_write held high across the ready cycle starts no new fetch that cycle. A new fetch starts the following cycle if instr_write is still 1.

## Test plan
- Reset, then instr_write=1 for 2 cycles, imem_ready in the 2nd with rdata=32'h8C22_0004:
  - imem_addr=0.
  - Then opcode=6'h23, rs=1, rt=2, imm=16'h0004.
  - instr_valid=1, fetch_count=1.
- Fetch with imem_ready delayed 3 cycles: fetch_stall=1 for 4 cycles, imem_req=1 for 4 cycles, pc unchanged throughout, IR loads on the 4th.
- pc_write=1, pc_source=00, alu_result=32'h4 in the ready cycle: pc=4 and IR loads on the same edge.
- Branch cases:
  - branch=1, zero=0: pc holds.
  - branch=1, zero=1, pc_source=01, alu_out=32'h40: pc=32'h40.
- pc=32'h1000_0000, IR=32'h0800_0010, pc_write=1, pc_source=10: pc=32'h1000_0040. alu_result=32'h7 with pc_source=00: pc=4 and misaligned pulses once.
- Assert reset during WAIT: imem_req=0 immediately, all outputs at reset values; an imem_ready pulse after reset release leaves instr_valid=0 and fetch_count=0.
